// File: rtl/ram_responder.sv
// Word-addressed RAM endpoint with programmable wait states. Accepts ramaddr/ramREN/ramWEN/ramstore; returns ramload/ramstate.
// Latency: LAT BUSY cycles, then one ACCESS cycle. With LAT==0, ACCESS follows the first edge that samples the request.
// Backpressure: requests are level-held until served. ACCESS lasts one cycle. A held request repeats with period LAT+1.
//
// Ports:
//   CLK       system clock, rising edge
//   nRST      asynchronous active-low reset
//   ramaddr   byte address; bits [1:0] are ignored unless error checking is built in
//   ramREN    read request (held until served)
//   ramWEN    write request (held until served); wins over ramREN
//   ramstore  write data
//   ramload   read data, valid while ramstate == ACCESS; holds otherwise
//   ramstate  FREE=0, BUSY=1, ACCESS=2, ERROR=3
//
// Optional build macro RAM_ERR_CHECK_EN:
//   An address out of range, a misaligned address, or ramREN and ramWEN high together
//   produce a one-cycle ERROR. In that case there is no array write and no ramload update.
//   Without the macro, the index wraps modulo DEPTH_WORDS, misalignment is ignored and ERROR is never driven.
module ram_responder #(
    parameter int LAT         = 2,
    parameter int DEPTH_WORDS = 1024,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] ramaddr,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int           CW    = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam logic [CW-1:0] LAT_C = CW'(LAT);

    logic [31:0] mem [DEPTH_WORDS];

    ramstate_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] ramload_q, ramload_d;

    logic          req;
    logic          changed;
    logic          bad_req;
    logic          acc;
    logic          acc_wr;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_data;
    logic          mem_we;

    assign req     = ramREN | ramWEN;
    // Any change to the captured request while waiting restarts the wait.
    assign changed = (ramaddr != addr_q) || (ramWEN != wr_q) || (ramstore != data_q);

`ifdef RAM_ERR_CHECK_EN
    assign bad_req = (ramaddr >= 32'(4 * DEPTH_WORDS)) || (ramaddr[1:0] != 2'b00) ||
                     (ramREN && ramWEN);
`else
    assign bad_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        data_d    = data_q;
        ramload_d = ramload_q;
        acc       = 1'b0;
        acc_wr    = wr_q;
        acc_idx   = addr_q[AW+1:2];
        acc_data  = data_q;

        case (state_q)
            BUSY: begin
                if (!req) begin
                    // The request was withdrawn before its access edge, so nothing is written.
                    state_d = FREE;
                end else if (changed) begin
                    addr_d = ramaddr;
                    wr_d   = ramWEN;
                    data_d = ramstore;
                    cnt_d  = LAT_C;
                    state_d = bad_req ? ERROR : BUSY;
                end else if (cnt_q == CW'(1)) begin
                    acc     = 1'b1;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            // FREE, ACCESS and ERROR all re-evaluate the bus as a fresh transaction.
            default: begin
                state_d = FREE;
                if (req) begin
                    addr_d = ramaddr;
                    wr_d   = ramWEN;
                    data_d = ramstore;
                    cnt_d  = LAT_C;
                    if (bad_req) begin
                        state_d = ERROR;
                    end else if (LAT == 0) begin
                        // With no wait states, the access happens on the sampling edge itself, using the live bus values.
                        acc      = 1'b1;
                        acc_wr   = ramWEN;
                        acc_idx  = ramaddr[AW+1:2];
                        acc_data = ramstore;
                        state_d  = ACCESS;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
        endcase

        if (acc && !acc_wr) begin
            ramload_d = mem[acc_idx];
        end
    end

    // The array write is qualified by nRST so that an access edge cannot occur while reset is held.
    assign mem_we = acc && acc_wr && nRST;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            ramload_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            ramload_q <= ramload_d;
        end
    end

    assign ramload  = ramload_q;
    assign ramstate = state_q;

endmodule
